// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with round-to-nearest-even,
// special-value handling, exception flags, sideband tag tracking and a global stall.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [EXP_W+MAN_W:0]     res,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0]        BIAS_X    = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_INF_X = XW'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // Denormals are flushed to zero; the sign is handled separately.
  function automatic cls_e classify(input logic [EXP_W+MAN_W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    cls_e             c;
    e = x[EXP_W+MAN_W-1:MAN_W];
    f = x[MAN_W-1:0];
    if (e == {EXP_W{1'b0}}) begin
      c = CLS_ZERO;
    end else if (e == {EXP_W{1'b1}}) begin
      c = (f == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  // Stage 1 registers
  logic                v1_r;
  logic [TAG_W-1:0]    tag1_r;
  logic [W-1:0]        a1_r;
  logic [W-1:0]        b1_r;

  // Stage 2 registers
  logic                v2_r;
  logic [TAG_W-1:0]    tag2_r;
  logic                sign2_r;
  logic signed [XW-1:0] exp2_r;
  logic [PW-1:0]       prod2_r;
  logic                nan2_r;
  logic                inf2_r;
  logic                zero2_r;

  // Stage 2 combinational signals
  cls_e                cls_a_s;
  cls_e                cls_b_s;
  logic                nan_s;
  logic                inf_s;
  logic                zero_s;
  logic signed [XW-1:0] exp_sum_s;
  logic [PW-1:0]       prod_s;

  // Stage 3 combinational signals
  logic                msb_s;
  logic [PW-2:0]       norm_s;
  logic [MAN_W-1:0]    frac_s;
  logic                guard_s;
  logic                sticky_s;
  logic                rnd_up_s;
  logic [MAN_W:0]      frac_rnd_s;
  logic signed [XW-1:0] exp_fin_s;
  logic                ovf_s;
  logic                unf_s;
  logic [W-1:0]        res_n_s;
  logic [3:0]          flags_n_s;

  // Stage 1: capture operands, tag and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r   <= 1'b0;
      tag1_r <= {TAG_W{1'b0}};
      a1_r   <= {W{1'b0}};
      b1_r   <= {W{1'b0}};
    end else if (!stall) begin
      v1_r   <= in_valid;
      tag1_r <= in_tag;
      a1_r   <= a;
      b1_r   <= b;
    end
  end

  // Operand classification, exponent sum and mantissa product.
  always_comb begin
    cls_a_s   = classify(a1_r[W-2:0]);
    cls_b_s   = classify(b1_r[W-2:0]);
    nan_s     = 1'b0;
    inf_s     = 1'b0;
    zero_s    = 1'b0;
    exp_sum_s = XW'(a1_r[W-2:MAN_W]) + XW'(b1_r[W-2:MAN_W]) - BIAS_X;
    prod_s    = PW'({1'b1, a1_r[MAN_W-1:0]}) * PW'({1'b1, b1_r[MAN_W-1:0]});
    if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN) ||
        ((cls_a_s == CLS_INF) && (cls_b_s == CLS_ZERO)) ||
        ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_INF))) begin
      nan_s = 1'b1;
    end else if ((cls_a_s == CLS_INF) || (cls_b_s == CLS_INF)) begin
      inf_s = 1'b1;
    end else if ((cls_a_s == CLS_ZERO) || (cls_b_s == CLS_ZERO)) begin
      zero_s = 1'b1;
    end else begin
      nan_s = 1'b0;
    end
  end

  // Stage 2: hold product, exponent and special-case class.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      tag2_r  <= {TAG_W{1'b0}};
      sign2_r <= 1'b0;
      exp2_r  <= {XW{1'b0}};
      prod2_r <= {PW{1'b0}};
      nan2_r  <= 1'b0;
      inf2_r  <= 1'b0;
      zero2_r <= 1'b0;
    end else if (!stall) begin
      v2_r    <= v1_r;
      tag2_r  <= tag1_r;
      sign2_r <= a1_r[W-1] ^ b1_r[W-1];
      exp2_r  <= exp_sum_s;
      prod2_r <= prod_s;
      nan2_r  <= nan_s;
      inf2_r  <= inf_s;
      zero2_r <= zero_s;
    end
  end

  // Normalise so the leading one is dropped, then round to nearest even.
  always_comb begin
    msb_s      = prod2_r[PW-1];
    norm_s     = msb_s ? prod2_r[PW-2:0] : {prod2_r[PW-3:0], 1'b0};
    frac_s     = norm_s[PW-2 -: MAN_W];
    guard_s    = norm_s[PW-2-MAN_W];
    sticky_s   = |norm_s[PW-3-MAN_W:0];
    rnd_up_s   = guard_s & (sticky_s | frac_s[0]);
    frac_rnd_s = {1'b0, frac_s} + (MAN_W+1)'(rnd_up_s);
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    exp_fin_s  = exp2_r + XW'(msb_s) + XW'(frac_rnd_s[MAN_W]);
    ovf_s      = (exp_fin_s >= EXP_INF_X);
    unf_s      = exp_fin_s[XW-1] | (exp_fin_s == {XW{1'b0}});
  end

  // Result selection in priority order.
  always_comb begin
    res_n_s   = {sign2_r, exp_fin_s[EXP_W-1:0], frac_rnd_s[MAN_W-1:0]};
    flags_n_s = {3'b000, guard_s | sticky_s};
    if (nan2_r) begin
      res_n_s   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_n_s = 4'b1000;
    end else if (inf2_r) begin
      res_n_s   = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n_s = 4'b0000;
    end else if (zero2_r) begin
      res_n_s   = {sign2_r, {(EXP_W+MAN_W){1'b0}}};
      flags_n_s = 4'b0000;
    end else if (ovf_s) begin
      res_n_s   = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n_s = 4'b0101;
    end else if (unf_s) begin
      res_n_s   = {sign2_r, {(EXP_W+MAN_W){1'b0}}};
      flags_n_s = 4'b0011;
    end else begin
      flags_n_s = {3'b000, guard_s | sticky_s};
    end
  end

  // Stage 3: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= {TAG_W{1'b0}};
      res       <= {W{1'b0}};
      flags     <= 4'b0000;
    end else if (!stall) begin
      out_valid <= v2_r;
      out_tag   <= tag2_r;
      res       <= res_n_s;
      flags     <= flags_n_s;
    end
  end

endmodule
